// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a built-in 16x oversampling tick generator.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DIV       = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);
  localparam int DW = $clog2(DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic r_pbit;
  logic r_perr;
  assign o_parity_err = r_perr;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t        r_state;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [DW-1:0] r_div;
  logic [3:0]    r_tcnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;
  logic          w_fall;
  logic          w_start;
  logic          w_tick;
  logic          w_mid;
  assign w_fall      = r_s3 & ~r_s2;
  assign w_start     = (r_state == IDLE) & w_fall;
  assign w_tick      = r_div == DW'(DIV - 1);
  assign w_mid       = w_tick & (r_tcnt == 4'd15);
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = r_busy;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_s3  <= 1'b1;
      r_div <= '0;
    end else begin
      r_s1  <= i_rxd;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_div <= (w_start | w_tick) ? '0 : r_div + 1'b1;
    end
  end
  // tcnt counts ticks since the last sample point; mid-bit is every 16th tick.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbit  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      if (w_tick) r_tcnt <= r_tcnt + 4'd1;
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          r_bit  <= '0;
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: if (w_tick && r_tcnt == 4'd7) begin
          r_tcnt  <= '0;
          r_state <= r_s2 ? IDLE : DATA;
          r_busy  <= ~r_s2;
        end
        DATA: if (w_mid) begin
          r_shift <= {r_s2, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_mid) begin
          r_pbit  <= r_s2;
          r_state <= STOP;
        end
`endif
        STOP: if (w_mid) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= r_s2;
          r_ferr  <= ~r_s2;
          if (r_s2) r_data <= r_shift;
`ifdef UART_RX_PARITY_EN
          r_perr  <= r_s2 & (^{r_shift, r_pbit});
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a monitor pops expected pulses from a queue.
module tb_uart_rx;
  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1683;
`else
  localparam int LAT = 1523;
`endif
  typedef struct {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif
  exp_t       q[$];
  exp_t       m_e;
  int         m_lat;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         busy_cnt;
  int         waited;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rb;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_rxd(rxd),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
`ifdef UART_RX_PARITY_EN
    , .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_frame_err)) begin
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        m_e   = q.pop_front();
        m_lat = cyc - m_e.t;
        chk("frame_err", int'(o_frame_err), int'(m_e.ferr));
        chk("valid", int'(o_valid), int'(!m_e.ferr));
        chk("data", int'(o_data), int'(m_e.data));
        chk("latency", (m_lat >= LAT - 1 && m_lat <= LAT + 1) ? LAT : m_lat, LAT);
`ifdef UART_RX_PARITY_EN
        chk("parity_err", int'(o_parity_err), int'(m_e.perr));
`endif
      end
    end
  end

  task automatic tx_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop, input logic perr);
    exp_t e;
    e.ferr = !stop;
    e.perr = stop & perr;
    e.data = stop ? d : last_good;
    e.t    = cyc;
    if (stop) last_good = d;
    q.push_back(e);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    tx_bit(par);
`else
    if (par === 1'bz) rxd = 1'b1;
`endif
    tx_bit(stop);
  endtask

  task automatic chk_reset_vals();
    chk("rst_data", int'(o_data), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_frame_err", int'(o_frame_err), 0);
    chk("rst_busy", int'(o_busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(o_busy), 0);
    send(8'hA5, ^8'hA5, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    send(8'h00, ^8'h00, 1'b1, 1'b0);
    send(8'hFF, ^8'hFF, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    busy_cnt = 0;
    rxd = 1'b0;
    repeat (60) begin @(negedge clk); busy_cnt += int'(o_busy); end
    rxd = 1'b1;
    repeat (240) begin @(negedge clk); busy_cnt += int'(o_busy); end
    checks++;
    if (busy_cnt < 1 || busy_cnt > 90) begin
      errors++;
      $display("FAIL glitch_busy: busy for %0d cycles, required 1..90", busy_cnt);
    end
    chk("glitch_busy_end", int'(o_busy), 0);
    send(8'h3C, ^8'h3C, 1'b0, 1'b0);
    repeat (3000) @(negedge clk);
    chk("break_busy", int'(o_busy), 0);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    send(8'h5A, ^8'h5A, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    rb = 8'hC3;
    tx_bit(1'b0);
    for (int i = 0; i < 4; i++) tx_bit(rb[i]);
    rxd = rb[4];
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    chk_reset_vals();
    repeat (75) @(negedge clk);
    tx_bit(rb[5]);
    rxd = rb[6];
    repeat (80) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    tx_bit(rb[7]);
`ifdef UART_RX_PARITY_EN
    tx_bit(^rb);
`endif
    tx_bit(1'b1);
    repeat (200) @(negedge clk);
    chk("abort_data_kept", int'(o_data), 0);
    send(8'h96, ^8'h96, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
`endif
    waited = 0;
    while (q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
